// File: rtl/aes_ctr_ctrl.sv
// ---------------------------------------------------------------------------
// aes_ctr_ctrl
//
// Sequencer that wraps an external AES-256 core to run CTR mode one block at a
// time. A block accepted on the input stream is sent to the core together with
// the current counter block. The keystream that comes back is XORed with the
// captured block and presented on the output stream. The counter field then
// advances for the next block.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   init                    one-cycle pulse: load iv/key_i, clear status, go idle
//   iv[127:0]               initial counter block (nonce || counter)
//   key_i[255:0]            AES-256 key, captured on init
//   in_valid/in_ready/in_data[127:0]     input block stream
//   out_valid/out_ready/out_data[127:0]  result block stream
//   core_text[127:0], core_key[255:0], core_start   drive to the AES core
//   core_done, core_result[127:0]                   completion from the AES core
//   busy                    a block is in flight (START, WAIT or OUT)
//   err                     counter wrapped; controller halted until init
//
// Parameter CTR_W (8..128): width of the incrementing field in the low bits of
// the counter block; the upper 128-CTR_W bits never change.
//
// Build option AES_CTR_WRAP_ERR_EN: when defined, a counter wrap still delivers
// its block, then raises err and parks in HALT after the output handshake.
// When undefined, the counter wraps silently and err is tied low.
// ---------------------------------------------------------------------------
module aes_ctr_ctrl #(
    parameter int CTR_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic [127:0] iv,
    input  logic [255:0] key_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [127:0] core_text,
    output logic [255:0] core_key,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic         busy,
    output logic         err
);

    // state | meaning
    // IDLE  | waiting for an input block (accepted only once loaded)
    // START | core_start pulse, counter block and key presented to the core
    // WAIT  | core running; core_text/core_key held stable
    // OUT   | result held on out_data until out_ready
    // HALT  | counter wrapped with wrap-error enabled; only init/reset leave
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Full-width mask of the counter field; CTR_W=128 would overflow the shift.
    localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                                       : ((128'd1 << CTR_W) - 128'd1);

    state_t       state_q;
    state_t       state_d;
    logic [127:0] ctr_q;
    logic [255:0] key_q;
    logic [127:0] data_q;
    logic [127:0] out_data_q;
    logic         out_valid_q;
    logic         loaded_q;
    logic         err_w;
    logic         accept;
    logic         done_w;
    logic         out_hs;
    logic [127:0] ctr_next;

`ifdef AES_CTR_WRAP_ERR_EN
    logic         err_q;
    logic         wrap_q;
    logic         ctr_at_max;

    assign ctr_at_max = ((ctr_q & CTR_MASK) == CTR_MASK);
    assign err_w      = err_q;
`else
    assign err_w      = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE) && loaded_q && !init && !err_w;
    assign accept     = in_valid && in_ready;
    // core_done is only meaningful while a block is outstanding.
    assign done_w     = (state_q == WAIT) && core_done;
    assign out_hs     = (state_q == OUT) && out_valid_q && out_ready;
    // Only the counter field advances; the nonce bits pass through untouched.
    assign ctr_next   = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

    assign core_start = (state_q == START);
    assign busy       = (state_q == START) || (state_q == WAIT) || (state_q == OUT);
    assign core_text  = ctr_q;
    assign core_key   = key_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err        = err_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = START;
                    end
                end
                START: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (out_hs) begin
`ifdef AES_CTR_WRAP_ERR_EN
                        state_d = wrap_q ? HALT : IDLE;
`else
                        state_d = IDLE;
`endif
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q       <= '0;
            key_q       <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            loaded_q    <= 1'b0;
        end else if (init) begin
            ctr_q       <= iv;
            key_q       <= key_i;
            out_valid_q <= 1'b0;
            loaded_q    <= 1'b1;
        end else begin
            if (accept) begin
                data_q <= in_data;
            end
            if (done_w) begin
                out_data_q  <= core_result ^ data_q;
                out_valid_q <= 1'b1;
                ctr_q       <= ctr_next;
            end
            if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef AES_CTR_WRAP_ERR_EN
    // The wrap is remembered at the increment and only surfaces as err once
    // the block that caused it has been handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else if (init) begin
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            if (done_w) begin
                wrap_q <= ctr_at_max;
            end
            if (out_hs && wrap_q) begin
                err_q  <= 1'b1;
                wrap_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_ctr_ctrl
//
// Randomized scoreboard bench for aes_ctr_ctrl (CTR_W = 32). A stand-in AES
// core answers core_start after a programmable latency with a keystream
// from core_fn(). For the NIST CTR-AES256 first counter block it returns
// the real keystream. Expected core inputs and output blocks are queued when
// a block is issued. The core model and the output monitor pop and compare
// them independently.
// ---------------------------------------------------------------------------
module tb_aes_ctr_ctrl;

    localparam logic [255:0] NIST_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] NIST_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] NIST_IN  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] NIST_OUT = 128'h601ec313775789a5b7a7f504bbf3d228;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init = 1'b0;
    logic [127:0] iv = '0;
    logic [255:0] key_i = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [127:0] core_text;
    logic [255:0] core_key;
    logic         core_start;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         busy;
    logic         err;

    aes_ctr_ctrl #(.CTR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .iv         (iv),
        .key_i      (key_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .core_text  (core_text),
        .core_key   (core_key),
        .core_start (core_start),
        .core_done  (core_done),
        .core_result(core_result),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_text_q[$];
    logic [255:0] exp_key_q[$];
    logic [127:0] exp_out_q[$];

    int           core_lat = 3;
    int           core_cnt = 0;
    logic [127:0] core_t = '0;
    logic [255:0] core_k = '0;
    bit           inject_done = 1'b0;
    int           starts = 0;
    int           blocks = 0;

    logic [127:0] m_ctr = '0;
    logic [255:0] m_key = '0;
    bit           m_wrap = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Keystream the stand-in core produces for a given counter block and key.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [255:0] k);
        if (t == NIST_IV && k == NIST_KEY) begin
            return NIST_OUT ^ NIST_IN;
        end
        return {t[63:0], t[127:64]} ^ k[255:128] ^ ~k[127:0] ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
    endfunction

    // Stand-in AES core plus the check of what it is asked to encrypt.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done   = 1'b1;
                core_result = core_fn(core_t, core_k);
            end
        end
        if (inject_done) begin
            inject_done = 1'b0;
            core_done   = 1'b1;
            core_result = rand128();
        end
        if (rst_n && core_start) begin
            starts++;
            core_t   = core_text;
            core_k   = core_key;
            core_cnt = core_lat;
            if (exp_text_q.size() == 0) begin
                check("unexpected_core_start", 256'(core_start), 256'(0));
            end else begin
                check("core_text", 256'(core_text), 256'(exp_text_q.pop_front()));
                check("core_key", core_key, exp_key_q.pop_front());
            end
        end
    end

    // Output monitor: every output handshake must match the next queued block.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_out_q.size() == 0) begin
                check("unexpected_out_valid", 256'(out_valid), 256'(0));
            end else begin
                check("out_data", 256'(out_data), 256'(exp_out_q.pop_front()));
            end
        end
    end

    task automatic do_init(input logic [127:0] v, input logic [255:0] k);
        @(posedge clk); #1;
        init  = 1'b1;
        iv    = v;
        key_i = k;
        m_ctr = v;
        m_key = k;
        m_wrap = 1'b0;
        @(posedge clk); #1;
        init  = 1'b0;
    endtask

    task automatic start_block(input logic [127:0] d, input bit expect_out);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_send", 256'(in_ready), 256'(1));
        if (!in_ready) return;
        in_valid = 1'b1;
        in_data  = d;
        exp_text_q.push_back(m_ctr);
        exp_key_q.push_back(m_key);
        if (expect_out) exp_out_q.push_back(core_fn(m_ctr, m_key) ^ d);
        m_wrap = (m_ctr[31:0] == 32'hffff_ffff);
        m_ctr  = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
        blocks++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand128();
        @(negedge clk);
        check("core_start_pulse", 256'(core_start), 256'(1));
        check("busy_in_start", 256'(busy), 256'(1));
    endtask

    task automatic finish_block(input int stall);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_arrives", 256'(out_valid), 256'(1));
        if (!out_valid) return;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 256'(out_valid), 256'(1));
            check("stall_in_ready", 256'(in_ready), 256'(0));
            if (exp_out_q.size() > 0) check("stall_out_data", 256'(out_data), 256'(exp_out_q[0]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_drops", 256'(out_valid), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v;
        logic [255:0] k;

        // Reset values
        #3;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_core_start", 256'(core_start), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(0));
        check("rst_core_text", 256'(core_text), 256'(0));
        check("rst_core_key", core_key, 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_ready_before_init", 256'(in_ready), 256'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // NIST CTR-AES256 vector, first block stalled 10 cycles, then block 2
        do_init(NIST_IV, NIST_KEY);
        core_lat = 4;
        start_block(NIST_IN, 1'b1);
        finish_block(10);
        start_block(rand128(), 1'b1);
        finish_block(0);

        // Random traffic with random latency, stall and occasional re-init
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) do_init(rand128(), {rand128(), rand128()});
            core_lat = $urandom_range(1, 6);
            start_block(rand128(), 1'b1);
            finish_block($urandom_range(0, 3));
        end

        // core_done while idle is ignored
        @(posedge clk); #1;
        inject_done = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_done_out_valid", 256'(out_valid), 256'(0));
        check("spurious_done_busy", 256'(busy), 256'(0));

        // init and in_valid in the same cycle: no capture, counter reloaded
        v = rand128();
        k = {rand128(), rand128()};
        @(posedge clk); #1;
        init = 1'b1; iv = v; key_i = k; in_valid = 1'b1; in_data = rand128();
        m_ctr = v; m_key = k; m_wrap = 1'b0;
        @(negedge clk);
        check("init_in_valid_ready", 256'(in_ready), 256'(0));
        @(posedge clk); #1;
        init = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("init_in_valid_busy", 256'(busy), 256'(0));
        core_lat = 2;
        start_block(rand128(), 1'b1);
        finish_block(1);

        // init while WAIT: abandon block, late core_done ignored
        core_lat = 8;
        start_block(rand128(), 1'b0);
        do_init(rand128(), {rand128(), rand128()});
        @(negedge clk);
        check("init_wait_busy", 256'(busy), 256'(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("init_wait_no_out", 256'(out_valid), 256'(0));
        end
        core_lat = 3;
        start_block(rand128(), 1'b1);
        finish_block(0);

        // Counter wrap
        do_init({rand128() & ~128'hffff_ffff} | 128'hffff_ffff, {rand128(), rand128()});
        start_block(rand128(), 1'b1);
        finish_block(0);
        check("wrap_flag_model", 256'(m_wrap), 256'(1));
`ifdef AES_CTR_WRAP_ERR_EN
        check("wrap_err_set", 256'(err), 256'(1));
        check("wrap_in_ready", 256'(in_ready), 256'(0));
        repeat (3) begin
            @(negedge clk);
            check("halt_in_ready", 256'(in_ready), 256'(0));
        end
        do_init(m_ctr, m_key);
        @(negedge clk);
        check("init_clears_err", 256'(err), 256'(0));
        check("init_restores_ready", 256'(in_ready), 256'(1));
`else
        check("wrap_err_tied", 256'(err), 256'(0));
        check("wrap_in_ready", 256'(in_ready), 256'(1));
`endif
        start_block(rand128(), 1'b1);
        finish_block(0);

        // Reset mid-WAIT
        core_lat = 6;
        start_block(rand128(), 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstw_out_valid", 256'(out_valid), 256'(0));
        check("rstw_core_start", 256'(core_start), 256'(0));
        check("rstw_busy", 256'(busy), 256'(0));
        check("rstw_err", 256'(err), 256'(0));
        check("rstw_in_ready", 256'(in_ready), 256'(0));
        check("rstw_core_text", 256'(core_text), 256'(0));
        check("rstw_core_key", core_key, 256'(0));
        check("rstw_out_data", 256'(out_data), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rstw_no_ready", 256'(in_ready), 256'(0));
            check("rstw_no_out", 256'(out_valid), 256'(0));
        end
        do_init(rand128(), {rand128(), rand128()});
        core_lat = 2;
        start_block(rand128(), 1'b1);
        finish_block(2);

        repeat (4) @(negedge clk);
        check("one_start_per_block", 256'(starts), 256'(blocks));
        check("out_queue_drained", 256'(exp_out_q.size()), 256'(0));
        check("text_queue_drained", 256'(exp_text_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
